nn_stream_bridge: RTL and testbench
===================================

Name: nn_stream_bridge

Overview:
Parametrised byte-stream to neural-layer bridge. Buffers incoming stream words in an internal FIFO. Once a full input frame of DIM_INPUT words is present, it bursts the frame into an FC layer as a contiguous valid train. It then captures the layer's DIM_OUTPUT-word result vector and serialises it out on a valid/ready master port. It sits between the UART RX path and the UART TX path. Unlike the first-generation top-level glue, it adds output backpressure, an end-of-frame marker, overflow and protocol error flags, and a frame counter.

Parameters:
DIM_INPUT, 96, words per input frame.
DIM_OUTPUT, 8, result words per frame (layer neuron count).
DATA_W, 8, word width.
FIFO_DEPTH, 128, input FIFO depth; power of 2 and >= DIM_INPUT.
CNT_W, 16, frame counter width.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
s_valid  in  1  input word strobe.
s_data  in  DATA_W  input word.
s_ready  out  1  FIFO not full.
lyr_dat  out  DATA_W  word to layer.
lyr_vld  out  1  layer input valid.
lyr_res  in  DIM_OUTPUT*DATA_W  layer result vector; word i at bits [i*DATA_W +: DATA_W].
lyr_res_vld  in  1  one-cycle result strobe.
m_data  out  DATA_W  output word.
m_valid  out  1  output valid.
m_ready  in  1  sink ready.
m_last  out  1  marks the last word of a frame.
ovf  out  1  sticky input overflow flag.
res_err  out  1  sticky flag: unexpected lyr_res_vld.
clr_err  in  1  synchronous clear of ovf and res_err.
frame_cnt  out  CNT_W  count of completed frames.
busy  out  1  FSM state is not IDLE.

Behaviour:
- Reset (async, rst=1): FIFO emptied; FSM in IDLE. All outputs 0: s_ready=1 once rst is released, lyr_vld, m_valid, m_last, ovf, res_err, frame_cnt, busy. Reset mid-frame discards the partial frame and any held results.
- Input side: a word is written when s_valid=1 and the FIFO is not full.
  - s_valid while full: word dropped, ovf set.
  - Writes are accepted in every FSM state, so the next frame fills while the current one is processed.
- FSM states and transitions:
  - IDLE: go to PUSH when the registered FIFO count >= DIM_INPUT.
  - PUSH: read one word per cycle for exactly DIM_INPUT cycles. The FIFO read data is registered. lyr_vld is high for exactly DIM_INPUT consecutive cycles, one cycle behind the reads. Go to WAIT after the last read.
  - WAIT: on lyr_res_vld, capture lyr_res into the result register and go to POP.
  - POP: present word index 0 first. Advance the index on each m_valid & m_ready. m_last=1 when index = DIM_OUTPUT-1. When the last word is accepted, increment frame_cnt (wraps at 2^CNT_W) and return to IDLE.
- Latency: the word that completes a frame is written on edge k. PUSH is entered on edge k+1. lyr_vld is first high after edge k+2.
- Output handshake: once m_valid is asserted, m_valid and m_data are held stable until accepted. m_valid never depends combinationally on m_ready.
- lyr_res_vld in any state other than WAIT: ignored, res_err set.
- Simultaneous write and read on the FIFO: count is unchanged. A full FIFO with a simultaneous read accepts the write; ovf is not set.
- clr_err clears the flags. If clr_err and a new error occur in the same cycle, the flag is set (set wins).
- frame_cnt is not cleared by clr_err.

Decomposition:
- Package nn_bridge_pkg: FSM state enum (IDLE, PUSH, WAIT, POP) and a function for the FIFO count width, $clog2(FIFO_DEPTH)+1.
- One sub-module, nn_sync_fifo: parametrised DATA_W/DEPTH, async active-high reset, registered dout and count, full/empty outputs. It is instantiated once.
- The FSM, result register and flags live in the top module.

Test Plan:
- Write 96 words 0..95 back-to-back; layer model returns {8'h07,...,8'h00}; m_ready=1 -> lyr_vld high for 96 contiguous cycles carrying 0..95 in order, first lyr_vld two edges after the 96th write; m_data 0..7 in order, m_last on the 8th word; frame_cnt=1.
- Same as above, but m_ready toggles 1-0-0-1 -> m_data holds while stalled, no word lost or duplicated, m_last only on word 7.
- Write 200 words without stopping, FIFO_DEPTH=128, layer held in WAIT -> s_ready falls at 128, ovf=1, words beyond capacity dropped; after clr_err, ovf=0.
- Write 95 words, idle 50 cycles -> no lyr_vld, busy=0. Write the 96th word -> PUSH starts.
- Pulse lyr_res_vld while IDLE -> res_err=1, no m_valid. Assert clr_err and a second stray strobe in the same cycle -> res_err stays 1.
- Assert rst in POP after 3 words accepted -> all outputs 0, FIFO empty. A fresh 96-word frame then produces a full 8-word output with frame_cnt=1.

Source files
------------

// File: rtl/nn_bridge_pkg.sv
// Shared types and helpers for the stream-to-layer bridge.
// Holds the control FSM state encoding and the FIFO occupancy width.
package nn_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PUSH,
    WAIT,
    POP
  } state_t;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the address.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Single-clock FIFO with registered read data and registered occupancy.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module nn_sync_fifo
  import nn_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  localparam int CW    = fifo_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // NOTE: the storage array is deliberately not reset; pointers and count define
  // what is valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nn_stream_bridge.sv
// Buffers a stream into frames, bursts each frame into an FC layer, then
// serialises the layer's result vector on a valid/ready port with a last marker.
module nn_stream_bridge
  import nn_bridge_pkg::*;
#(
  parameter int DIM_INPUT  = 96,
  parameter int DIM_OUTPUT = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 128,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  output logic [DATA_W-1:0]            lyr_dat,
  output logic                         lyr_vld,
  input  logic [DIM_OUTPUT*DATA_W-1:0] lyr_res,
  input  logic                         lyr_res_vld,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         ovf,
  output logic                         res_err,
  input  logic                         clr_err,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic                         busy
);

  localparam int CW    = fifo_cnt_w(FIFO_DEPTH);
  localparam int RCW   = (DIM_INPUT > 1) ? $clog2(DIM_INPUT) : 1;
  localparam int IDX_W = (DIM_OUTPUT > 1) ? $clog2(DIM_OUTPUT) : 1;

  localparam logic [CW-1:0]    DIM_IN_C = CW'(DIM_INPUT);
  localparam logic [RCW-1:0]   RD_LAST  = RCW'(DIM_INPUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM_OUTPUT - 1);

  state_t                       state;
  logic [RCW-1:0]               rd_cnt;
  logic [IDX_W-1:0]             idx;
  logic [IDX_W-1:0]             idx_nxt;
  logic [DIM_OUTPUT*DATA_W-1:0] res_q;

  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf_set;
  logic              res_set;

  nn_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (s_valid),
    .din   (s_data),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_rd = (state == PUSH);
  assign s_ready = ~fifo_full & ~rst;
  assign lyr_dat = fifo_dout;
  assign busy    = (state != IDLE);
  assign idx_nxt = idx + 1'b1;

  // A full FIFO still takes the word when the same cycle pops one out.
  assign ovf_set = s_valid & fifo_full & ~fifo_rd;
  assign res_set = lyr_res_vld & (state != WAIT);

  // m_valid/m_data/m_last are registered, so m_valid never looks at m_ready
  // combinationally and the presented word holds until it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      lyr_vld   <= 1'b0;
      res_q     <= '0;
      idx       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      lyr_vld <= fifo_rd;
      case (state)
        IDLE: begin
          if (fifo_count >= DIM_IN_C) begin
            rd_cnt <= '0;
            state  <= PUSH;
          end
        end
        PUSH: begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == RD_LAST) state <= WAIT;
        end
        WAIT: begin
          if (lyr_res_vld) begin
            res_q   <= lyr_res;
            idx     <= '0;
            m_data  <= lyr_res[DATA_W-1:0];
            m_last  <= (DIM_OUTPUT == 1);
            m_valid <= 1'b1;
            state   <= POP;
          end
        end
        POP: begin
          if (m_valid && m_ready) begin
            if (idx == IDX_LAST) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= IDLE;
            end else begin
              idx    <= idx_nxt;
              m_data <= res_q[int'(idx_nxt)*DATA_W +: DATA_W];
              m_last <= (idx_nxt == IDX_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      res_err <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (res_set)      res_err <= 1'b1;
      else if (clr_err) res_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nn_stream_bridge.sv
// Directed bench for nn_stream_bridge: frame bursts, output backpressure,
// overflow, stray result strobes, partial-frame hold-off and mid-frame reset.
module tb_nn_stream_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [7:0]  lyr_dat;
  logic        lyr_vld;
  logic [63:0] lyr_res;
  logic        lyr_res_vld;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        ovf;
  logic        res_err;
  logic        clr_err;
  logic [15:0] frame_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nn_stream_bridge #(
    .DIM_INPUT  (96),
    .DIM_OUTPUT (8),
    .DATA_W     (8),
    .FIFO_DEPTH (128),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .lyr_dat     (lyr_dat),
    .lyr_vld     (lyr_vld),
    .lyr_res     (lyr_res),
    .lyr_res_vld (lyr_res_vld),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .ovf         (ovf),
    .res_err     (res_err),
    .clr_err     (clr_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Waits for the layer burst, then checks 96 contiguous words base..base+95.
  task automatic check_train(input logic [7:0] base, output int lat);
    int errs;
    errs = 0;
    lat  = 0;
    while (lyr_vld !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    for (int j = 0; j < 96; j++) begin
      if (lyr_vld !== 1'b1 || lyr_dat !== base + 8'(j)) errs++;
      @(negedge clk);
    end
    check("train_errs", errs, 0);
    check("train_end", lyr_vld, 1'b0);
  endtask

  task automatic respond(input logic [7:0] rb);
    for (int i = 0; i < 8; i++) lyr_res[i*8 +: 8] = rb + 8'(i);
    lyr_res_vld = 1'b1;
    @(negedge clk);
    lyr_res_vld = 1'b0;
  endtask

  // Drains up to stop_after words, optionally with an m_ready 1-0-0-1 pattern.
  task automatic collect(input logic [7:0] rb, input bit toggle, input int stop_after);
    bit         pat [4];
    int         got;
    int         errs;
    int         cyc;
    bit         stalled;
    logic [7:0] held;
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1};
    got     = 0;
    errs    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (got < stop_after && cyc < 200) begin
      m_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (stalled && (m_valid !== 1'b1 || m_data !== held)) errs++;
      if (m_valid === 1'b1 && m_last !== (got == 7)) errs++;
      if (m_valid !== 1'b1 && m_last !== 1'b0) errs++;
      if (m_valid === 1'b1 && m_ready) begin
        if (m_data !== rb + 8'(got)) errs++;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = (m_valid === 1'b1);
        held    = m_data;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = (stop_after < 8) ? 1'b0 : 1'b1;
    check("out_count", got, stop_after);
    check("out_errs", errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int saw;
    int first_block;
    int accepted;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; lyr_res = '0; lyr_res_vld = 1'b0;
    m_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_lyr_vld", lyr_vld, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_busy", busy, 1'b0);

    // Frame A: m_ready held high
    write_words(8'h00, 96);
    check("a_busy_at_k", busy, 1'b0);
    check_train(8'h00, lat);
    check("a_latency", lat, 2);
    check("a_wait_busy", busy, 1'b1);
    check("a_wait_no_valid", m_valid, 1'b0);
    respond(8'h00);
    check("a_first_valid", m_valid, 1'b1);
    check("a_first_data", m_data, 8'h00);
    collect(8'h00, 1'b0, 8);
    check("a_done_valid", m_valid, 1'b0);
    check("a_frame_cnt", frame_cnt, 16'd1);
    check("a_idle", busy, 1'b0);

    // Frame B: m_ready toggling 1-0-0-1
    write_words(8'h80, 96);
    check_train(8'h80, lat);
    respond(8'h10);
    collect(8'h10, 1'b1, 8);
    check("b_frame_cnt", frame_cnt, 16'd2);

    // 95 words must not start a frame; the 96th does
    write_words(8'h40, 95);
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      if (lyr_vld !== 1'b0 || busy !== 1'b0) saw++;
      @(negedge clk);
    end
    check("partial_no_start", saw, 0);
    write_words(8'h40 + 8'd95, 1);
    check_train(8'h40, lat);
    check("partial_latency", lat, 2);
    respond(8'h20);
    collect(8'h20, 1'b0, 8);
    check("partial_frame_cnt", frame_cnt, 16'd3);

    // Stray result strobe in IDLE, then clear racing a second stray strobe
    lyr_res_vld = 1'b1;
    @(negedge clk);
    lyr_res_vld = 1'b0;
    check("stray_res_err", res_err, 1'b1);
    check("stray_no_valid", m_valid, 1'b0);
    check("stray_idle", busy, 1'b0);
    lyr_res_vld = 1'b1;
    clr_err     = 1'b1;
    @(negedge clk);
    lyr_res_vld = 1'b0;
    check("set_wins_res_err", res_err, 1'b1);
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_res_err", res_err, 1'b0);

    // Overflow while the layer sits in WAIT
    write_words(8'h00, 96);
    check_train(8'h00, lat);
    first_block = -1;
    accepted    = 0;
    for (int i = 0; i < 200; i++) begin
      if (s_ready === 1'b1) accepted++;
      else if (first_block < 0) first_block = i;
      s_valid = 1'b1;
      s_data  = 8'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("ovf_first_block", first_block, 128);
    check("ovf_accepted", accepted, 128);
    check("ovf_flag", ovf, 1'b1);
    check("ovf_s_ready_low", s_ready, 1'b0);
    check("ovf_no_res_err", res_err, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovf_cleared", ovf, 1'b0);
    respond(8'h30);
    collect(8'h30, 1'b0, 8);
    check("ovf_frame_cnt", frame_cnt, 16'd4);
    check_train(8'h00, lat);

    // Reset in POP after three accepted words
    respond(8'h50);
    collect(8'h50, 1'b0, 3);
    check("pop_still_valid", m_valid, 1'b1);
    check("pop_word3", m_data, 8'h53);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_last", m_last, 1'b0);
    check("mid_rst_lyr_vld", lyr_vld, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_frame_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);
    write_words(8'hA0, 96);
    check_train(8'hA0, lat);
    check("post_rst_latency", lat, 2);
    respond(8'h70);
    check("post_rst_first_valid", m_valid, 1'b1);
    collect(8'h70, 1'b0, 8);
    check("post_rst_frame_cnt", frame_cnt, 16'd1);
    check("post_rst_done_valid", m_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
